// File: rtl/psram_qpi_responder.sv
// Responder model of a 4-bit serial pseudo-SRAM: serial command on SIO0, quad address,
// quad write/read bursts against a small internal byte array with a backdoor read port.
module psram_qpi_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_CYCLES = 4
) (
   input  logic                 i_clkRAM,
   input  logic                 reset,
   input  logic                 i_psram_cs,
   inout  wire  [3:0]           io_psram_data,
   output logic                 o_qpiMode,
   output logic [7:0]           o_lastCmd,
   output logic                 o_active,
   input  logic [ADDR_BITS-1:0] i_bdAddr,
   output logic [7:0]           o_bdData
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CMD    = 3'd1;
   localparam logic [2:0] ADDR   = 3'd2;
   localparam logic [2:0] WDATA  = 3'd3;
   localparam logic [2:0] RWAIT  = 3'd4;
   localparam logic [2:0] RDATA  = 3'd5;
   localparam logic [2:0] IGNORE = 3'd6;

   localparam logic [7:0] K_CMD_LAST  = 8'd7;
   localparam logic [7:0] K_ADDR_LAST = 8'd13;
   localparam logic [7:0] K_FETCH     = 8'(13 + WAIT_CYCLES);

   logic [2:0]           state;
   logic [7:0]           k_q;
   logic [7:0]           cmd_q;
   logic [7:0]           cmd_next;
   logic [ADDR_BITS-1:0] addr_q;
   logic                 wr_mode;
   logic                 nib_lo;
   logic                 rst_d;
   logic                 oe;
   logic                 wr_en;
   logic [3:0]           wr_hi;
   logic [3:0]           sio_in;
   logic [3:0]           sio_out;
   logic [7:0]           rd_byte;
   logic [7:0]           mem [2**ADDR_BITS];

   assign sio_in        = io_psram_data;
   assign io_psram_data = oe ? sio_out : 4'bzzzz;
   assign cmd_next      = {cmd_q[6:0], sio_in[0]};
   assign o_active      = (state != IDLE);
   assign o_bdData      = mem[i_bdAddr];
   assign wr_en         = !reset && !i_psram_cs && (state == WDATA) && nib_lo;

   always_ff @(posedge i_clkRAM) begin
      if (wr_en) begin
         mem[addr_q] <= {wr_hi, sio_in};
      end
   end

   always_ff @(posedge i_clkRAM) begin
      if (reset) begin
         state     <= IDLE;
         k_q       <= 8'd0;
         nib_lo    <= 1'b0;
         oe        <= 1'b0;
         wr_mode   <= 1'b0;
         o_qpiMode <= 1'b0;
         o_lastCmd <= 8'h00;
         rst_d     <= 1'b1;
      end else begin
         rst_d <= 1'b0;
         if (i_psram_cs) begin
            state  <= IDLE;
            oe     <= 1'b0;
            k_q    <= 8'd0;
            nib_lo <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // A transaction already under way when reset released is not ours to decode.
                  cmd_q  <= {7'd0, sio_in[0]};
                  k_q    <= 8'd1;
                  nib_lo <= 1'b0;
                  state  <= rst_d ? IGNORE : CMD;
               end
               CMD: begin
                  cmd_q <= cmd_next;
                  k_q   <= k_q + 8'd1;
                  if (k_q == K_CMD_LAST) begin
                     o_lastCmd <= cmd_next;
                     case (cmd_next)
                        8'h35: begin
                           o_qpiMode <= 1'b1;
                           state     <= IGNORE;
                        end
                        8'h38: begin
                           wr_mode <= 1'b1;
                           state   <= ADDR;
                        end
                        8'hEB: begin
                           wr_mode <= 1'b0;
                           state   <= ADDR;
                        end
                        default: state <= IGNORE;
                     endcase
                  end
               end
               ADDR: begin
                  // Only the low ADDR_BITS survive the shift, which gives the aliasing for free.
                  addr_q <= {addr_q[ADDR_BITS-5:0], sio_in};
                  k_q    <= k_q + 8'd1;
                  if (k_q == K_ADDR_LAST) begin
                     state <= wr_mode ? WDATA : RWAIT;
                  end
               end
               WDATA: begin
                  nib_lo <= !nib_lo;
                  if (!nib_lo) begin
                     wr_hi <= sio_in;
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
               RWAIT: begin
                  k_q <= k_q + 8'd1;
                  if (k_q == K_FETCH) begin
                     rd_byte <= mem[addr_q];
                     state   <= RDATA;
                  end
               end
               RDATA: begin
                  oe     <= 1'b1;
                  nib_lo <= !nib_lo;
                  if (!nib_lo) begin
                     sio_out <= rd_byte[7:4];
                  end else begin
                     sio_out <= rd_byte[3:0];
                     rd_byte <= mem[addr_q + 1'b1];
                     addr_q  <= addr_q + 1'b1;
                  end
               end
               IGNORE: oe <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: serial command, quad write/read, wrap, aliasing,
// aborted transactions and reset in the middle of a write.
`timescale 1ns/1ps
module tb_psram_qpi_responder;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        tb_drv;
   logic [3:0]  tb_sio;
   wire  [3:0]  sio;
   logic        qpi;
   logic [7:0]  last_cmd;
   logic        active;
   logic [11:0] bd_addr;
   logic [7:0]  bd_data;
   int          checks;
   int          errors;

   assign sio = tb_drv ? tb_sio : 4'bzzzz;

   psram_qpi_responder #(.ADDR_BITS(12), .WAIT_CYCLES(4)) dut (
      .i_clkRAM      (clk),
      .reset         (reset),
      .i_psram_cs    (cs),
      .io_psram_data (sio),
      .o_qpiMode     (qpi),
      .o_lastCmd     (last_cmd),
      .o_active      (active),
      .i_bdAddr      (bd_addr),
      .o_bdData      (bd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One sampled edge with the given bus values; returns just after that edge.
   task automatic cyc(input logic c, input logic [3:0] d, input logic de);
      cs     = c;
      tb_sio = d;
      tb_drv = de;
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] c);
      for (int i = 7; i >= 0; i--) cyc(1'b0, {3'b000, c[i]}, 1'b1);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int n = 5; n >= 0; n--) cyc(1'b0, a[n*4 +: 4], 1'b1);
   endtask

   task automatic send_data(input logic [7:0] b);
      cyc(1'b0, b[7:4], 1'b1);
      cyc(1'b0, b[3:0], 1'b1);
   endtask

   task automatic end_txn();
      cyc(1'b1, 4'h0, 1'b0);
   endtask

   task automatic bd_chk(input string tag, input logic [11:0] a, input logic [7:0] e);
      bd_addr = a;
      #1;
      chk(tag, {24'd0, bd_data}, {24'd0, e});
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      cs      = 1'b1;
      tb_drv  = 1'b0;
      tb_sio  = 4'h0;
      bd_addr = 12'h000;
      cyc(1'b1, 4'h0, 1'b0);
      cyc(1'b1, 4'h0, 1'b0);
      chk("rst_qpi", {31'd0, qpi}, 32'd0);
      chk("rst_lastcmd", {24'd0, last_cmd}, 32'h00);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rst_oe", {31'd0, dut.oe}, 32'd0);
      reset = 1'b0;
      cyc(1'b1, 4'h0, 1'b0);

      // 0x35: status bit only, never drives the bus
      send_cmd(8'h35);
      chk("qpi_set", {31'd0, qpi}, 32'd1);
      chk("qpi_lastcmd", {24'd0, last_cmd}, 32'h35);
      chk("qpi_active", {31'd0, active}, 32'd1);
      chk("qpi_oe", {31'd0, dut.oe}, 32'd0);
      end_txn();
      chk("qpi_idle", {31'd0, active}, 32'd0);

      // neighbours, then the byte under test
      send_cmd(8'h38); send_addr(24'h000122);
      send_data(8'h01); send_data(8'h02); send_data(8'h03);
      end_txn();
      send_cmd(8'h38); send_addr(24'h000123);
      send_data(8'hA5);
      end_txn();
      chk("wr_lastcmd", {24'd0, last_cmd}, 32'h38);
      bd_chk("wr_122", 12'h122, 8'h01);
      bd_chk("wr_123", 12'h123, 8'hA5);
      bd_chk("wr_124", 12'h124, 8'h03);

      // read with 4 wait cycles: k=14..17 quiet, data from k=18
      send_cmd(8'hEB); send_addr(24'h000123);
      chk("rd_oe_k13", {31'd0, dut.oe}, 32'd0);
      for (int i = 14; i <= 17; i++) cyc(1'b0, 4'h0, 1'b0);
      chk("rd_oe_k17", {31'd0, dut.oe}, 32'd0);
      cyc(1'b0, 4'h0, 1'b0);
      chk("rd_oe_k18", {31'd0, dut.oe}, 32'd1);
      chk("rd_hi_k18", {28'd0, sio}, 32'hA);
      cyc(1'b0, 4'h0, 1'b0);
      chk("rd_lo_k19", {28'd0, sio}, 32'h5);
      cyc(1'b0, 4'h0, 1'b0);
      chk("rd_hi_k20", {28'd0, sio}, 32'h0);
      cyc(1'b0, 4'h0, 1'b0);
      chk("rd_lo_k21", {28'd0, sio}, 32'h3);
      end_txn();
      chk("rd_oe_end", {31'd0, dut.oe}, 32'd0);
      chk("rd_idle", {31'd0, active}, 32'd0);

      // burst across the top of the array
      send_cmd(8'h38); send_addr(24'h000FFF);
      send_data(8'h11); send_data(8'h22);
      end_txn();
      bd_chk("wrap_fff", 12'hFFF, 8'h11);
      bd_chk("wrap_000", 12'h000, 8'h22);

      // upper address bits alias
      send_cmd(8'h38); send_addr(24'hABC456);
      send_data(8'h7E);
      end_txn();
      bd_chk("alias_456", 12'h456, 8'h7E);

      // high nibble only, then deselect
      send_cmd(8'h38); send_addr(24'h000123);
      cyc(1'b0, 4'hC, 1'b1);
      end_txn();
      bd_chk("abort_nib", 12'h123, 8'hA5);

      // unknown command
      send_cmd(8'h9F);
      chk("unk_lastcmd", {24'd0, last_cmd}, 32'h9F);
      chk("unk_active", {31'd0, active}, 32'd1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'hF, 1'b1);
      chk("unk_oe", {31'd0, dut.oe}, 32'd0);
      end_txn();
      bd_chk("unk_123", 12'h123, 8'hA5);
      bd_chk("unk_000", 12'h000, 8'h22);

      // reset at k=10 of a write with cs held low
      send_cmd(8'h38); send_addr(24'h000200);
      send_data(8'h55);
      end_txn();
      bd_chk("pre_200", 12'h200, 8'h55);
      send_cmd(8'h38);
      cyc(1'b0, 4'h0, 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      reset = 1'b1;
      cyc(1'b0, 4'h0, 1'b1);
      reset = 1'b0;
      chk("mid_rst_active", {31'd0, active}, 32'd0);
      chk("mid_rst_qpi", {31'd0, qpi}, 32'd0);
      cyc(1'b0, 4'h2, 1'b1);
      chk("mid_rst_ignore", {31'd0, active}, 32'd1);
      cyc(1'b0, 4'h0, 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      send_data(8'h66);
      send_data(8'h38);
      send_data(8'h66);
      end_txn();
      chk("mid_rst_lastcmd", {24'd0, last_cmd}, 32'h00);
      bd_chk("mid_rst_200", 12'h200, 8'h55);
      send_cmd(8'h38); send_addr(24'h000200);
      send_data(8'h99);
      end_txn();
      chk("after_rst_lastcmd", {24'd0, last_cmd}, 32'h38);
      bd_chk("after_rst_200", 12'h200, 8'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/psram_qpi_responder.md
Name: psram_qpi_responder

Overview:
- Synthesizable single-die model of the LY68S3200 serial pseudo-SRAM, 4-bit I/O. It is the responder end of the PSRAM bus driven by the memory controller.
- Used in simulation and on FPGA loopback builds in place of the physical chip.
- Decodes serial command bytes, captures quad addresses, and stores or returns data from a small internal array.
- On the board, two instances sit side by side, one per data nibble group.

Parameters:
- ADDR_BITS, 12: implemented array depth is 2^ADDR_BITS bytes. Address bits above ADDR_BITS-1 are ignored (aliasing).
- WAIT_CYCLES, 4: number of sample cycles between the last address nibble (k=13) and the read launch. The high read nibble is launched at sample index k = 14+WAIT_CYCLES.

Ports:
- i_clkRAM  in  1  PSRAM SCLK and sole clock; all activity is on posedge.
- reset  in  1  synchronous, active-high.
- i_psram_cs  in  1  chip select, active low.
- io_psram_data  inout  4  SIO[3:0]; SIO0 is SI during the command phase.
- o_qpiMode  out  1  set by command 0x35.
- o_lastCmd  out  8  last completed command byte.
- o_active  out  1  transaction in progress (state is not IDLE).
- i_bdAddr  in  ADDR_BITS  backdoor read address, for benches.
- o_bdData  out  8  combinational array read at i_bdAddr.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; outputs reset to o_qpiMode=0, o_lastCmd=8'h00, o_active=0; oe=0, so io_psram_data is Z.
  - Array contents are not reset.
  - If i_psram_cs is low when reset releases, go to IGNORE.
- Sample index k: 0 on the first posedge where i_psram_cs is sampled 0, incrementing by 1 per posedge while cs stays 0.
- States and transitions:
  - IDLE: when cs=0, shift in SIO0 as cmd bit 7 and go to CMD.
  - CMD (k=1..7): shift SIO0 in MSB first. At k=7 decode the byte and set o_lastCmd:
    - 0x35: set o_qpiMode=1, go to IGNORE.
    - 0x38: go to ADDR, mode=write.
    - 0xEB: go to ADDR, mode=read.
    - any other byte: go to IGNORE.
  - ADDR (k=8..13): capture nibbles A[23:20] first, down to A[3:0], from SIO[3:0] (SIO0 = LSB of the nibble). At k=13, write mode goes to WDATA, read mode goes to RWAIT.
  - WDATA: sample pairs, high nibble first. On each low nibble, write the byte to array[addr[ADDR_BITS-1:0]], then addr+1. Address wraps modulo 2^ADDR_BITS. Burst continues while cs=0.
  - RWAIT: oe=0 for k=14..13+WAIT_CYCLES. At the k=13+WAIT_CYCLES edge, fetch the byte and go to RDATA.
  - RDATA:
    - At k=14+WAIT_CYCLES, launch byte[7:4] on SIO[3:0] (registered) and set oe=1.
    - At the next edge, launch byte[3:0].
    - Then continue alternating; the next byte is fetched at addr+1 with wrap.
    - oe stays 1 until cs is sampled high.
  - IGNORE: oe=0 and no array access until cs is sampled high.
- In every state, cs sampled 1 forces IDLE on that edge, clears oe to 0 on that edge, and clears the bit/nibble counters. This applies to:
  - cs high in mid-command or mid-address: transaction dropped, nothing written.
  - cs high after a write high nibble only: that partial byte is discarded, earlier bytes are kept.
- Command entry is always serial on SIO0. o_qpiMode is status only and does not change decoding.
- In read mode, SIO inputs are ignored after k=13.
- o_active=1 whenever state is not IDLE.
- The array is written only in WDATA. One write port and one backdoor read port; the read-data fetch uses the same synchronous read path.

Test Plan:
- Reset, then drive cs=0 with serial 0x35 over 8 clocks, then cs=1 -> o_qpiMode=1, o_lastCmd=8'h35, io_psram_data Z throughout.
- Write 0x38, addr 0x000123, data 0xA5, then cs=1 -> o_bdData=8'hA5 at i_bdAddr=0x123; neighbouring bytes unchanged.
- Read 0xEB, addr 0x000123, WAIT_CYCLES=4 -> SIO=4'hA launched at k=18, 4'h5 at k=19; Z at k≤17 and Z one edge after cs high.
- Burst write at addr 0x000FFF of 0x11 then 0x22 (ADDR_BITS=12) -> array[0xFFF]=0x11, array[0x000]=0x22 (wrap).
- Abort cases:
  - cs high after write high nibble 0xC only -> target byte unchanged.
  - Command 0x9F -> IGNORE, no drive, no write, o_lastCmd=8'h9F.
- Assert reset at k=10 of a write with cs still low -> IGNORE, no write; next transaction after cs high behaves normally.
